// File: rtl/io_bus_bridge_if.sv
// CPU data-port and IO bus signal bundle for io_bus_bridge.
// cpu_err is present only when IO_BRIDGE_ERR_EN is defined.
interface io_bus_bridge_if;
    logic        cpu_valid;
    logic        cpu_ready;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic [7:0]  io_addr;
    logic        io_en;
    logic        io_we;
    logic [31:0] io_data_write;
    logic [31:0] io_data_read;
    logic        wbuf_empty;
`ifdef IO_BRIDGE_ERR_EN
    logic        cpu_err;
`endif

    // Bridge side: requests are taken when cpu_valid && cpu_ready in the same
    // cycle; a requester holds cpu_valid and its payload stable until then.
    modport slave (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, io_data_read,
        output cpu_ready, cpu_rvalid, cpu_rdata, io_addr, io_en, io_we,
               io_data_write, wbuf_empty
`ifdef IO_BRIDGE_ERR_EN
        , output cpu_err
`endif
    );

    modport master (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata, io_data_read,
        input  cpu_ready, cpu_rvalid, cpu_rdata, io_addr, io_en, io_we,
               io_data_write, wbuf_empty
`ifdef IO_BRIDGE_ERR_EN
        , input cpu_err
`endif
    );
endinterface

// File: rtl/io_bus_bridge.sv
// CPU data-port to IO bus bridge with a posted-write FIFO; reads wait behind buffered writes.
// Optional macro IO_BRIDGE_ERR_EN adds cpu_err for out-of-window accesses.
module io_bus_bridge #(
    parameter logic [31:0] IO_BASE    = 32'h8000_0000,
    parameter int unsigned WBUF_DEPTH = 4,
    parameter int unsigned IO_RD_LAT  = 0
) (
    input  logic           clk,
    input  logic           reset,
    io_bus_bridge_if.slave bus,
    output logic [1:0]     dbg_state_o
);
    localparam int unsigned PW = $clog2(WBUF_DEPTH);
    localparam int unsigned CW = $clog2(WBUF_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RESP     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      rd_addr_q, rd_addr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      lat_q, lat_d;
    logic [7:0]      hold_addr_q, hold_addr_d;
    logic [31:0]     hold_data_q, hold_data_d;
    logic [39:0]     mem_q [WBUF_DEPTH];

    logic            in_win;
    logic            ready_c;
    logic            accept;
    logic            push;
    logic            pop;
    logic            io_en_c;
    logic            io_we_c;
    logic [7:0]      io_addr_c;
    logic [31:0]     io_wdata_c;
    logic            rvalid_c;

    assign in_win  = (bus.cpu_addr[31:8] == IO_BASE[31:8]);
    // Reset gates the handshake so nothing is taken in the reset cycle itself.
    assign ready_c = !reset && (state_q == ST_IDLE) && (count_q < CW'(WBUF_DEPTH));
    assign accept  = bus.cpu_valid && ready_c;
    assign push    = accept && bus.cpu_we && in_win;
    assign pop     = !reset && (count_q != '0) && (state_q != ST_RD_ISSUE);

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        rdata_d    = rdata_q;
        lat_d      = lat_q;
        io_en_c    = 1'b0;
        io_we_c    = 1'b0;
        io_addr_c  = hold_addr_q;
        io_wdata_c = hold_data_q;
        rvalid_c   = 1'b0;

        if (pop) begin
            io_en_c    = 1'b1;
            io_we_c    = 1'b1;
            io_addr_c  = mem_q[rd_ptr_q][39:32];
            io_wdata_c = mem_q[rd_ptr_q][31:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && !bus.cpu_we) begin
                    if (in_win) begin
                        rd_addr_d = bus.cpu_addr[7:0];
                        state_d   = ST_DRAIN;
                    end else begin
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_DRAIN: begin
                lat_d = '0;
                if (count_q == '0) begin
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                io_en_c   = !reset;
                io_we_c   = 1'b0;
                io_addr_c = rd_addr_q;
                // Data is captured only on the final cycle of the held strobe.
                if (lat_q == 2'(IO_RD_LAT)) begin
                    rdata_d = bus.io_data_read;
                    state_d = ST_RESP;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_RESP: begin
                rvalid_c = !reset;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        hold_addr_d = io_addr_c;
        hold_data_d = io_wdata_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_addr_q   <= '0;
            rdata_q     <= '0;
            lat_q       <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_addr_q   <= rd_addr_d;
            rdata_q     <= rdata_d;
            lat_q       <= lat_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cpu_addr[7:0], bus.cpu_wdata};
        end
    end

`ifdef IO_BRIDGE_ERR_EN
    logic err_wr_q;
    logic oow_rd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_wr_q <= 1'b0;
            oow_rd_q <= 1'b0;
        end else begin
            err_wr_q <= accept && bus.cpu_we && !in_win;
            if (accept && !bus.cpu_we) begin
                oow_rd_q <= !in_win;
            end
        end
    end

    assign bus.cpu_err = !reset && (err_wr_q || ((state_q == ST_RESP) && oow_rd_q));
`endif

    assign bus.cpu_ready     = ready_c;
    assign bus.cpu_rvalid    = rvalid_c;
    assign bus.cpu_rdata     = rdata_q;
    assign bus.io_en         = io_en_c;
    assign bus.io_we         = io_we_c;
    assign bus.io_addr       = io_addr_c;
    assign bus.io_data_write = io_wdata_c;
    assign bus.wbuf_empty    = (count_q == '0) && (state_q == ST_IDLE);
    assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_io_bus_bridge.sv
// Directed and randomized bench for io_bus_bridge (default build and IO_RD_LAT=2 instance).
module tb_io_bus_bridge;
    logic        clk;
    logic        reset;
    int unsigned cyc;
    int          pass_cnt;
    int          fail_cnt;
    int          total_cnt;
    logic        mon_on;
    logic        rd_fixed_en;
    logic [31:0] rd_fixed;
    logic [1:0]  dbg0;
    logic [1:0]  dbg2;
    logic [40:0] exp_io_q [$];
    logic [31:0] exp_rd_q [$];
    logic [40:0] mon_e;
    logic [31:0] mon_r;

    io_bus_bridge_if bus0 ();
    io_bus_bridge_if bus2 ();

    io_bus_bridge u_dut0 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus0),
        .dbg_state_o (dbg0)
    );

    io_bus_bridge #(.IO_RD_LAT(2)) u_dut2 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus2),
        .dbg_state_o (dbg2)
    );

    function automatic logic [31:0] rd_func(input logic [7:0] a);
        return {a, ~a, 8'h3C, a ^ 8'h5A};
    endfunction

    assign bus0.io_data_read = rd_fixed_en ? rd_fixed : rd_func(bus0.io_addr);
    assign bus2.io_data_read = 32'hD000_0000 + 32'(cyc);

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        total_cnt++;
        fail_cnt++;
        $error("FAIL %s: observed no event expected event within bound", tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: call just after a rising edge; returns just after the accepting edge
    task automatic cpu_req(input logic we, input logic [31:0] addr, input logic [31:0] data);
        int n;
        bus0.cpu_valid = 1'b1;
        bus0.cpu_we    = we;
        bus0.cpu_addr  = addr;
        bus0.cpu_wdata = data;
        n = 0;
        @(negedge clk);
        while (!bus0.cpu_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) fail_now("cpu_ready_timeout");
        @(posedge clk);
        #1;
        bus0.cpu_valid = 1'b0;
        if (mon_on) begin
            if (addr[31:8] == 24'h80_0000) begin
                if (we) exp_io_q.push_back({1'b1, addr[7:0], data});
                else begin
                    exp_io_q.push_back({1'b0, addr[7:0], 32'h0});
                    exp_rd_q.push_back(rd_func(addr[7:0]));
                end
            end else if (!we) begin
                exp_rd_q.push_back(32'h0);
            end
        end
    endtask

    // scoreboard monitor for the randomized phase
    always @(negedge clk) begin
        if (mon_on) begin
            if (bus0.io_en) begin
                if (exp_io_q.size() == 0) fail_now("io_unexpected_strobe");
                else begin
                    mon_e = exp_io_q.pop_front();
                    chk("rnd_io_we", 40'(bus0.io_we), 40'(mon_e[40]));
                    chk("rnd_io_addr", 40'(bus0.io_addr), 40'(mon_e[39:32]));
                    if (mon_e[40]) chk("rnd_io_wdata", 40'(bus0.io_data_write), 40'(mon_e[31:0]));
                end
            end
            if (bus0.cpu_rvalid) begin
                if (exp_rd_q.size() == 0) fail_now("rvalid_unexpected");
                else begin
                    mon_r = exp_rd_q.pop_front();
                    chk("rnd_rdata", 40'(bus0.cpu_rdata), 40'(mon_r));
                end
            end
        end
    end

    initial begin
        logic [7:0]  a5 [5];
        logic [31:0] d5 [5];
        logic [31:0] exp2;
        logic [31:0] wd;
        logic [31:0] ra;
        int          n;

        cyc = 0; pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
        mon_on = 1'b0; rd_fixed_en = 1'b0; rd_fixed = 32'h0;
        reset = 1'b1;
        bus0.cpu_valid = 1'b0; bus0.cpu_we = 1'b0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0;
        bus2.cpu_valid = 1'b0; bus2.cpu_we = 1'b0; bus2.cpu_addr = '0; bus2.cpu_wdata = '0;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cycle_ready", 40'(bus0.cpu_ready), 40'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 40'(bus0.cpu_ready), 40'h1);
        chk("rst_rvalid", 40'(bus0.cpu_rvalid), 40'h0);
        chk("rst_rdata", 40'(bus0.cpu_rdata), 40'h0);
        chk("rst_io_en", 40'(bus0.io_en), 40'h0);
        chk("rst_io_we", 40'(bus0.io_we), 40'h0);
        chk("rst_io_addr", 40'(bus0.io_addr), 40'h0);
        chk("rst_io_wdata", 40'(bus0.io_data_write), 40'h0);
        chk("rst_wbuf_empty", 40'(bus0.wbuf_empty), 40'h1);
`ifdef IO_BRIDGE_ERR_EN
        chk("rst_err", 40'(bus0.cpu_err), 40'h0);
`endif
        step();

        // single write: strobe one cycle after acceptance, for exactly one cycle
        cpu_req(1'b1, 32'h8000_0000, 32'h0000_005A);
        @(negedge clk);
        chk("w1_io_en", 40'(bus0.io_en), 40'h1);
        chk("w1_io_we", 40'(bus0.io_we), 40'h1);
        chk("w1_io_addr", 40'(bus0.io_addr), 40'h0);
        chk("w1_io_wdata", 40'(bus0.io_data_write), 40'h5A);
        @(negedge clk);
        chk("w1_io_en_off", 40'(bus0.io_en), 40'h0);
        chk("w1_addr_hold", 40'(bus0.io_addr), 40'h0);
        chk("w1_wdata_hold", 40'(bus0.io_data_write), 40'h5A);
        step();

        // five back-to-back writes: no stall, strobes back-to-back and in order
        a5[0] = 8'h00; a5[1] = 8'h01; a5[2] = 8'h10; a5[3] = 8'h14; a5[4] = 8'h18;
        for (int i = 0; i < 5; i++) d5[i] = $urandom;
        for (int i = 0; i < 5; i++) begin
            bus0.cpu_valid = 1'b1; bus0.cpu_we = 1'b1;
            bus0.cpu_addr = {24'h80_0000, a5[i]}; bus0.cpu_wdata = d5[i];
            @(negedge clk);
            chk("b2b_ready", 40'(bus0.cpu_ready), 40'h1);
            if (i > 0) begin
                chk("b2b_io_en", 40'(bus0.io_en & bus0.io_we), 40'h1);
                chk("b2b_io_addr", 40'(bus0.io_addr), 40'(a5[i-1]));
                chk("b2b_io_wdata", 40'(bus0.io_data_write), 40'(d5[i-1]));
            end
            step();
        end
        bus0.cpu_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_en", 40'(bus0.io_en & bus0.io_we), 40'h1);
        chk("b2b_last_addr", 40'(bus0.io_addr), 40'h18);
        chk("b2b_last_wdata", 40'(bus0.io_data_write), 40'(d5[4]));
        @(negedge clk);
        chk("b2b_idle_en", 40'(bus0.io_en), 40'h0);
        chk("b2b_empty", 40'(bus0.wbuf_empty), 40'h1);
        step();

        // two writes then a read: writes strobe first, rvalid five cycles after first write
        rd_fixed_en = 1'b1; rd_fixed = 32'h1234_5678;
        cpu_req(1'b1, 32'h8000_0004, 32'hAAAA_0001);
        @(negedge clk);
        chk("wr_rd_w0_addr", 40'(bus0.io_addr), 40'h04);
        chk("wr_rd_w0_we", 40'(bus0.io_en & bus0.io_we), 40'h1);
        step();
        bus0.cpu_valid = 1'b0;
        cpu_req(1'b1, 32'h8000_0008, 32'hAAAA_0002);
        cpu_req(1'b0, 32'h8000_0010, 32'h0);
        n = 3;
        @(negedge clk);
        chk("wr_rd_drain_en", 40'(bus0.io_en), 40'h0);
        chk("wr_rd_drain_ready", 40'(bus0.cpu_ready), 40'h0);
        @(negedge clk);
        n++;
        chk("wr_rd_rd_en", 40'(bus0.io_en), 40'h1);
        chk("wr_rd_rd_we", 40'(bus0.io_we), 40'h0);
        chk("wr_rd_rd_addr", 40'(bus0.io_addr), 40'h10);
        @(negedge clk);
        n++;
        chk("wr_rd_rvalid_at5", 40'(bus0.cpu_rvalid), 40'h1);
        chk("wr_rd_rdata", 40'(bus0.cpu_rdata), 40'h1234_5678);
        @(negedge clk);
        chk("wr_rd_rvalid_off", 40'(bus0.cpu_rvalid), 40'h0);
        chk("wr_rd_ready_back", 40'(bus0.cpu_ready), 40'h1);
        rd_fixed_en = 1'b0;
        step();

        // out-of-window read and write
        cpu_req(1'b0, 32'h0000_0100, 32'h0);
        @(negedge clk);
        chk("oow_rd_rvalid", 40'(bus0.cpu_rvalid), 40'h1);
        chk("oow_rd_rdata", 40'(bus0.cpu_rdata), 40'h0);
        chk("oow_rd_no_io", 40'(bus0.io_en), 40'h0);
`ifdef IO_BRIDGE_ERR_EN
        chk("oow_rd_err", 40'(bus0.cpu_err), 40'h1);
`endif
        @(negedge clk);
        chk("oow_rd_rvalid_off", 40'(bus0.cpu_rvalid), 40'h0);
        step();
        cpu_req(1'b1, 32'h7FFF_FF04, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("oow_wr_no_io", 40'(bus0.io_en), 40'h0);
`ifdef IO_BRIDGE_ERR_EN
        chk("oow_wr_err", 40'(bus0.cpu_err), 40'h1);
`endif
        @(negedge clk);
        chk("oow_wr_empty", 40'(bus0.wbuf_empty), 40'h1);
`ifdef IO_BRIDGE_ERR_EN
        chk("oow_wr_err_off", 40'(bus0.cpu_err), 40'h0);
`endif
        step();

        // IO_RD_LAT=2: strobe held three cycles, data from the last one
        bus2.cpu_valid = 1'b1; bus2.cpu_we = 1'b0; bus2.cpu_addr = 32'h8000_0020;
        @(negedge clk);
        chk("lat2_ready", 40'(bus2.cpu_ready), 40'h1);
        step();
        bus2.cpu_valid = 1'b0;
        exp2 = 32'hD000_0000 + 32'(cyc) + 32'd3;
        @(negedge clk);
        chk("lat2_drain_en", 40'(bus2.io_en), 40'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lat2_rd_en", 40'(bus2.io_en), 40'h1);
            chk("lat2_rd_we", 40'(bus2.io_we), 40'h0);
            chk("lat2_rd_addr", 40'(bus2.io_addr), 40'h20);
            chk("lat2_no_rvalid", 40'(bus2.cpu_rvalid), 40'h0);
        end
        @(negedge clk);
        chk("lat2_rvalid", 40'(bus2.cpu_rvalid), 40'h1);
        chk("lat2_rdata", 40'(bus2.cpu_rdata), 40'(exp2));
        chk("lat2_io_en_off", 40'(bus2.io_en), 40'h0);
        @(negedge clk);
        chk("lat2_rvalid_off", 40'(bus2.cpu_rvalid), 40'h0);
        step();

        // reset during DRAIN: outstanding read dropped
        cpu_req(1'b1, 32'h8000_0030, 32'h3333_3333);
        cpu_req(1'b0, 32'h8000_0040, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("mid_rst_io_en", 40'(bus0.io_en), 40'h0);
            chk("mid_rst_rvalid", 40'(bus0.cpu_rvalid), 40'h0);
            if (k == 0) begin
                chk("mid_rst_empty", 40'(bus0.wbuf_empty), 40'h1);
                chk("mid_rst_ready", 40'(bus0.cpu_ready), 40'h1);
            end
        end
        step();

        // randomized traffic against the queue-based reference
        mon_on = 1'b1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) step();
            wd = $urandom;
            if ($urandom_range(0, 9) < 7) ra = {24'h80_0000, 8'($urandom_range(0, 255))};
            else ra = $urandom & 32'h7FFF_FFFF;
            cpu_req(1'($urandom_range(0, 1)), ra, wd);
        end
        n = 0;
        @(negedge clk);
        while ((exp_io_q.size() != 0 || exp_rd_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) fail_now("rnd_drain_timeout");
        mon_on = 1'b0;
        @(negedge clk);
        chk("rnd_end_empty", 40'(bus0.wbuf_empty), 40'h1);
        chk("rnd_end_io_en", 40'(bus0.io_en), 40'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
